// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the N-slave Wishbone classic interconnect.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } ic_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          ERR_CNT_W        = 16;

  // Width of a slave index; a single-slave bus still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_ic_addr_decode.sv
// Combinational priority address decoder: lowest-index matching window wins.
module wb_ic_addr_decode
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int AW         = 32,
  parameter int IW         = idx_width(NUM_SLAVES),
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = '1
) (
  input  logic [AW-1:0] adr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Scan from the highest index down so the lowest matching index is the last writer.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit = 1'b1;
        idx = IW'(i);
      end else begin
        hit = hit;
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/wb_ic_nslave.sv
// Single-master, N-slave Wishbone classic interconnect with unmapped-address
// error, ack timeout, master abort and a saturating error counter.
module wb_ic_nslave
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = '1,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     m_wb_cyc_i,
  input  logic                     m_wb_stb_i,
  input  logic                     m_wb_we_i,
  input  logic [DW/8-1:0]          m_wb_sel_i,
  input  logic [AW-1:0]            m_wb_adr_i,
  input  logic [DW-1:0]            m_wb_dat_i,
  output logic [DW-1:0]            m_wb_dat_o,
  output logic                     m_wb_ack_o,
  output logic                     m_wb_err_o,
  output logic [NUM_SLAVES-1:0]    s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_wb_stb_o,
  output logic                     s_wb_we_o,
  output logic [DW/8-1:0]          s_wb_sel_o,
  output logic [AW-1:0]            s_wb_adr_o,
  output logic [DW-1:0]            s_wb_dat_o,
  input  logic [NUM_SLAVES*DW-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_wb_ack_i,
  output logic [ERR_CNT_W-1:0]     err_cnt_o
);

  localparam int IW = idx_width(NUM_SLAVES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_SLAVES-1:0] ONE_HOT0   = NUM_SLAVES'(1);

  ic_state_e                state_r, state_n;
  logic [IW-1:0]            sel_idx_r, sel_idx_n;
  logic                     we_r, we_n;
  logic [AW-1:0]            adr_r, adr_n;
  logic [DW-1:0]            wdat_r, wdat_n;
  logic [DW/8-1:0]          bsel_r, bsel_n;
  logic [TW-1:0]            timer_r, timer_n;
  logic [NUM_SLAVES-1:0]    stb_r, stb_n;
  logic                     m_ack_r, m_ack_n;
  logic                     m_err_r, m_err_n;
  logic [DW-1:0]            m_dat_r, m_dat_n;
  logic [ERR_CNT_W-1:0]     err_cnt_r, err_cnt_n;
  logic                     hit_s;
  logic [IW-1:0]            idx_s;

  wb_ic_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (AW),
    .IW         (IW),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .adr (m_wb_adr_i),
    .hit (hit_s),
    .idx (idx_s)
  );

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_n   = state_r;
    sel_idx_n = sel_idx_r;
    we_n      = we_r;
    adr_n     = adr_r;
    wdat_n    = wdat_r;
    bsel_n    = bsel_r;
    timer_n   = timer_r;
    stb_n     = stb_r;
    m_ack_n   = 1'b0;
    m_err_n   = 1'b0;
    m_dat_n   = m_dat_r;
    err_cnt_n = err_cnt_r;
    case (state_r)
      IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i) begin
          we_n   = m_wb_we_i;
          adr_n  = m_wb_adr_i;
          wdat_n = m_wb_dat_i;
          bsel_n = m_wb_sel_i;
          if (hit_s) begin
            state_n   = REQ;
            sel_idx_n = idx_s;
            stb_n     = ONE_HOT0 << idx_s;
            timer_n   = '0;
          end else begin
            state_n = ERR;
            stb_n   = '0;
          end
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        // Abort outranks ack, and ack outranks a timeout landing on the same edge.
        if (!m_wb_cyc_i) begin
          stb_n   = '0;
          state_n = IDLE;
        end else if (s_wb_ack_i[sel_idx_r]) begin
          stb_n   = '0;
          m_ack_n = 1'b1;
          state_n = RESP;
          if (!we_r) begin
            m_dat_n = s_wb_dat_i[sel_idx_r*DW +: DW];
          end else begin
            m_dat_n = m_dat_r;
          end
        end else if (timer_r == TIMER_LAST) begin
          stb_n   = '0;
          state_n = ERR;
        end else begin
          timer_n = timer_r + 1'b1;
        end
      end
      ERR: begin
        m_ack_n = 1'b1;
        m_err_n = 1'b1;
        m_dat_n = ERR_DATA;
        state_n = RESP;
        if (err_cnt_r != '1) begin
          err_cnt_n = err_cnt_r + 1'b1;
        end else begin
          err_cnt_n = err_cnt_r;
        end
      end
      RESP: begin
        // Master's strobe is still high this cycle; it must not start a new transfer.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        stb_n   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= IDLE;
      sel_idx_r <= '0;
      we_r      <= 1'b0;
      adr_r     <= '0;
      wdat_r    <= '0;
      bsel_r    <= '0;
      timer_r   <= '0;
      stb_r     <= '0;
      m_ack_r   <= 1'b0;
      m_err_r   <= 1'b0;
      m_dat_r   <= '0;
      err_cnt_r <= '0;
    end else begin
      state_r   <= state_n;
      sel_idx_r <= sel_idx_n;
      we_r      <= we_n;
      adr_r     <= adr_n;
      wdat_r    <= wdat_n;
      bsel_r    <= bsel_n;
      timer_r   <= timer_n;
      stb_r     <= stb_n;
      m_ack_r   <= m_ack_n;
      m_err_r   <= m_err_n;
      m_dat_r   <= m_dat_n;
      err_cnt_r <= err_cnt_n;
    end
  end

  assign m_wb_dat_o = m_dat_r;
  assign m_wb_ack_o = m_ack_r;
  assign m_wb_err_o = m_err_r;
  assign s_wb_cyc_o = stb_r;
  assign s_wb_stb_o = stb_r;
  assign s_wb_we_o  = we_r;
  assign s_wb_sel_o = bsel_r;
  assign s_wb_adr_o = adr_r;
  assign s_wb_dat_o = wdat_r;
  assign err_cnt_o  = err_cnt_r;

endmodule

// File: tb/tb_wb_ic_nslave.sv
// Directed, table-driven bench for wb_ic_nslave with 4 slaves and an 8-cycle timeout.
module tb_wb_ic_nslave;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_cyc, m_stb, m_we;
  logic [3:0]   m_sel;
  logic [31:0]  m_adr, m_dat, m_dat_o;
  logic         m_ack, m_err;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [31:0]  s_adr, s_dat_o;
  logic [127:0] s_dat_i;
  logic [3:0]   s_ack;
  logic [15:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Slave 3 window (0x3000_0000..0x3000_7FFF) overlaps slaves 0..2.
  wb_ic_nslave #(
    .NUM_SLAVES  (4),
    .AW          (32),
    .DW          (32),
    .SLV_BASE    ({32'h3000_0000, 32'h3000_2000, 32'h3000_1000, 32'h3000_0000}),
    .SLV_MASK    ({32'hFFFF_8000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT_CYC (8),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .m_wb_cyc_i (m_cyc),
    .m_wb_stb_i (m_stb),
    .m_wb_we_i  (m_we),
    .m_wb_sel_i (m_sel),
    .m_wb_adr_i (m_adr),
    .m_wb_dat_i (m_dat),
    .m_wb_dat_o (m_dat_o),
    .m_wb_ack_o (m_ack),
    .m_wb_err_o (m_err),
    .s_wb_cyc_o (s_cyc),
    .s_wb_stb_o (s_stb),
    .s_wb_we_o  (s_we),
    .s_wb_sel_o (s_sel),
    .s_wb_adr_o (s_adr),
    .s_wb_dat_o (s_dat_o),
    .s_wb_dat_i (s_dat_i),
    .s_wb_ack_i (s_ack),
    .err_cnt_o  (err_cnt)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          slave;      // responding slave, -1 none
    int          waits;      // wait states before ack, -1 never acks
    logic [31:0] rdat;
    int          spur;       // slave driving a spurious ack every cycle, -1 none
    logic [3:0]  exp_stb;
    int          exp_stb_cyc;
    int          exp_lat;    // edges from request edge to the edge sampling m_ack
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int c;
    int stb_cyc;
    int lat;
    bit bad_stb;
    bit seen;
    logic        err_seen;
    logic [31:0] dat_seen;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = v.we; m_adr = v.adr; m_dat = v.wdat; m_sel = v.sel;
    s_ack = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      s_dat_i[i*32 +: 32] = (i == v.slave) ? v.rdat : (32'hBAD0_0000 | 32'(i));
    end
    @(posedge clk); #1;
    c = 0; stb_cyc = 0; lat = 0; bad_stb = 1'b0; seen = 1'b0;
    err_seen = 1'b0; dat_seen = 32'h0;
    while (!seen && c < 40) begin
      if (s_stb != 4'b0000) begin
        stb_cyc++;
        if (s_stb !== v.exp_stb || s_cyc !== v.exp_stb) bad_stb = 1'b1;
      end
      if (c == 0 && v.exp_stb != 4'b0000) begin
        chk({name, "_s_adr"}, 64'(s_adr), 64'(v.adr));
        chk({name, "_s_we"}, 64'(s_we), 64'(v.we));
        chk({name, "_s_wdat"}, 64'(s_dat_o), 64'(v.wdat));
        chk({name, "_s_sel"}, 64'(s_sel), 64'(v.sel));
      end
      if (m_ack) begin
        seen = 1'b1; lat = c + 1; err_seen = m_err; dat_seen = m_dat_o;
      end else begin
        s_ack = 4'b0000;
        if (v.waits >= 0 && v.slave >= 0 && c >= v.waits && s_stb[v.slave]) s_ack[v.slave] = 1'b1;
        if (v.spur >= 0) s_ack[v.spur] = 1'b1;
        @(posedge clk); #1;
        c++;
      end
    end
    chk({name, "_stb_onehot"}, 64'(bad_stb), 64'(0));
    chk({name, "_stb_cycles"}, 64'(stb_cyc), 64'(v.exp_stb_cyc));
    chk({name, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({name, "_m_err"}, 64'(err_seen), 64'(v.exp_err));
    chk({name, "_m_dat"}, 64'(dat_seen), 64'(v.exp_dat));
    // Master samples the ack on this edge with stb still high, then releases.
    @(posedge clk); #1;
    s_ack = 4'b0000;
    m_cyc = 1'b0; m_stb = 1'b0;
    chk({name, "_ack_pulse"}, 64'(m_ack), 64'(0));
    chk({name, "_err_cnt"}, 64'(err_cnt), 64'(v.exp_cnt));
    @(posedge clk); #1;
    chk({name, "_no_reissue"}, 64'(s_stb), 64'(0));
  endtask

  initial begin
    int acks;
    //          we    adr            wdat           sel      slv wt  rdat           spur stb      cyc lat err   dat            cnt
    vecs[0] = '{1'b1, 32'h3000_1004, 32'hA5A5_5A5A, 4'b1111,  1,  0, 32'h0000_0000, -1, 4'b0010, 1,  2, 1'b0, 32'h0000_0000, 16'd0};
    vecs[1] = '{1'b0, 32'h3000_2010, 32'h0000_0000, 4'b1111,  2,  3, 32'h1234_5678, -1, 4'b0100, 4,  5, 1'b0, 32'h1234_5678, 16'd0};
    vecs[2] = '{1'b0, 32'h4000_0000, 32'h0000_0000, 4'b1111, -1, -1, 32'h0000_0000, -1, 4'b0000, 0,  2, 1'b1, 32'hDEAD_BEEF, 16'd1};
    vecs[3] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'b1111,  0, -1, 32'h0000_0000, -1, 4'b0001, 8, 10, 1'b1, 32'hDEAD_BEEF, 16'd2};
    vecs[4] = '{1'b0, 32'h3000_1ABC, 32'h0000_0000, 4'b1111,  1,  2, 32'hCAFE_F00D,  3, 4'b0010, 3,  4, 1'b0, 32'hCAFE_F00D, 16'd2};
    vecs[5] = '{1'b0, 32'h3000_3000, 32'h0000_0000, 4'b1111,  3,  1, 32'h0F0F_1234, -1, 4'b1000, 2,  3, 1'b0, 32'h0F0F_1234, 16'd2};
    vecs[6] = '{1'b1, 32'h3000_0100, 32'h1122_3344, 4'b0011,  0,  0, 32'h5555_AAAA, -1, 4'b0001, 1,  2, 1'b0, 32'h0F0F_1234, 16'd2};
    vecs[7] = '{1'b0, 32'h3000_2004, 32'h0000_0000, 4'b1111,  2,  7, 32'h7777_0007, -1, 4'b0100, 8,  9, 1'b0, 32'h7777_0007, 16'd2};
    vecs[8] = '{1'b0, 32'h3000_2020, 32'h0000_0000, 4'b1111,  2,  8, 32'h8888_0008, -1, 4'b0100, 8, 10, 1'b1, 32'hDEAD_BEEF, 16'd3};

    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = 4'b0000;
    m_adr = 32'h0; m_dat = 32'h0; s_dat_i = '0; s_ack = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_ack", 64'(m_ack), 64'(0));
    chk("rst_m_err", 64'(m_err), 64'(0));
    chk("rst_m_dat", 64'(m_dat_o), 64'(0));
    chk("rst_s_stb", 64'({s_cyc, s_stb}), 64'(0));
    chk("rst_s_adr", 64'(s_adr), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Master abort while the selected slave is stalled.
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h3000_2000; s_ack = 4'b0000;
    @(posedge clk); #1;
    chk("abort_stb_on", 64'(s_stb), 64'(4'b0100));
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    chk("abort_stb_off", 64'({s_cyc, s_stb}), 64'(0));
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      if (m_ack) acks++;
      @(posedge clk); #1;
    end
    chk("abort_no_ack", 64'(acks), 64'(0));
    chk("abort_err_cnt", 64'(err_cnt), 64'(3));

    // Reset while a request is outstanding.
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h3000_1000;
    @(posedge clk); #1;
    chk("rstreq_stb_on", 64'(s_stb), 64'(4'b0010));
    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    chk("rstreq_stb_off", 64'({s_cyc, s_stb}), 64'(0));
    chk("rstreq_m_ack", 64'(m_ack), 64'(0));
    chk("rstreq_err_cnt", 64'(err_cnt), 64'(0));
    chk("rstreq_m_dat", 64'(m_dat_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (m_ack) acks++;
    end
    chk("rstreq_no_ack", 64'(acks), 64'(0));

    run_txn(vecs[2], "post_rst_unmapped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
